// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - memory-mapped 8N1 UART receiver with byte FIFO and DATA/STATUS registers.
// Optional 8E1 parity checking is enabled by defining SERIAL_RX_PARITY_EN.
module serial_rx #(
  parameter int CLK_HZ       = 10_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  input  logic        sel,
  input  logic        re,
  input  logic [31:0] addr,
  output logic [31:0] dout,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic          r_sync1, r_sync2;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitn;
  logic [7:0]    r_shift;
  logic          r_brk;
  logic          r_push;
  logic [7:0]    r_push_data;
  logic          r_frame_evt;
  logic          w_rx_s;
  logic          w_par_flag;
`ifdef SERIAL_RX_PARITY_EN
  logic          r_par_bit;
  logic          r_par_evt;
  logic          r_parity_err;
`endif

  assign w_rx_s = r_sync2;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM; emits one-cycle push/error pulses consumed by the FIFO/register block.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bitn      <= '0;
      r_shift     <= '0;
      r_brk       <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_frame_evt <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      r_par_bit   <= 1'b0;
      r_par_evt   <= 1'b0;
`endif
    end else begin
      r_push      <= 1'b0;
      r_frame_evt <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      r_par_evt   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_cnt   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_bitn  <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt           <= '0;
            r_shift[r_bitn] <= w_rx_s;
            r_bitn          <= r_bitn + 3'd1;
            if (r_bitn == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == FULL_M1) begin
            r_cnt     <= '0;
            r_par_bit <= w_rx_s;
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (r_brk) begin
            // Broken stop bit: hold here until the line returns to idle.
            if (w_rx_s) begin
              r_brk   <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end
          end else if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_state <= S_IDLE;
`ifdef SERIAL_RX_PARITY_EN
              if (^{r_shift, r_par_bit}) begin
                r_par_evt <= 1'b1;
              end else begin
                r_push      <= 1'b1;
                r_push_data <= r_shift;
              end
`else
              r_push      <= 1'b1;
              r_push_data <= r_shift;
`endif
            end else begin
              r_frame_evt <= 1'b1;
              r_brk       <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic        r_overrun, r_frame_err;
  logic [AW:0] w_count;
  logic [8:0]  w_count9;
  logic        w_empty, w_full, w_data_rd, w_stat_rd, w_pop, w_wr, w_ovf;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_count   = r_wptr - r_rptr;
  assign w_count9  = 9'(w_count);
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_data_rd = sel & re & ~addr[2];
  assign w_stat_rd = sel & re & addr[2];
  assign w_pop     = w_data_rd & ~w_empty;
  assign w_wr      = r_push & ~w_full;
  assign w_ovf     = r_push & w_full;
`ifdef SERIAL_RX_PARITY_EN
  assign w_par_flag = r_parity_err;
`else
  assign w_par_flag = 1'b0;
`endif
  assign w_status  = {16'b0, w_count9[7:0], 4'b0, w_par_flag, r_overrun, r_frame_err, ~w_empty};
  assign irq       = ~w_empty;
  assign w_unused  = ^{addr[31:3], addr[1:0], w_count9[8]};

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_push_data;
  end

  // Status reads clear the sticky flags, but a same-edge error event keeps its flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      dout         <= '0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (w_wr)  r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
      if (w_data_rd) begin
        dout <= w_empty ? 32'h0000_0100 : {24'b0, r_mem[r_rptr[AW-1:0]]};
      end else if (w_stat_rd) begin
        dout <= w_status;
      end
      r_overrun    <= (r_overrun & ~w_stat_rd) | w_ovf;
      r_frame_err  <= (r_frame_err & ~w_stat_rd) | r_frame_evt;
`ifdef SERIAL_RX_PARITY_EN
      r_parity_err <= (r_parity_err & ~w_stat_rd) | r_par_evt;
`endif
    end
  end

endmodule
